// File: rtl/jtframe_rom_client.sv
// Cached ROM read client: serves game reads from a 32-bit SDRAM port through a small tag cache.
// Define JTFRAME_ROM_CLIENT_2WAY_EN for two round-robin entries; default is a single entry.
module jtframe_rom_client #(
  parameter int          AW     = 16,
  parameter int          DW     = 8,
  parameter logic [21:0] OFFSET = 22'd0,
  parameter logic [1:0]  BANK   = 2'd0
)(
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          loop_rst,
  input  logic [AW-1:0] addr,
  input  logic          cs,
  output logic [DW-1:0] dout,
  output logic          data_ok,
  output logic          sdram_req,
  output logic [21:0]   sdram_addr,
  output logic [1:0]    sdram_bank,
  input  logic          sdram_ack,
  input  logic [31:0]   data_read,
  input  logic          data_rdy
);
  localparam int LB = (DW == 16) ? 1 : 2;
  localparam int IW = AW - LB;
`ifdef JTFRAME_ROM_CLIENT_2WAY_EN
  localparam int NE = 2;
`else
  localparam int NE = 1;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

  state_t          state_r, state_s;
  logic [IW-1:0]   idx_s;
  logic [LB-1:0]   lane_s;
  logic            valid_r [NE];
  logic [IW-1:0]   tag_r   [NE];
  logic [31:0]     data_r  [NE];
  logic            rptr_r;
  logic [IW-1:0]   req_idx_r;
  logic            hit_s;
  logic [31:0]     hit_data_s;
  logic [DW-1:0]   lane_data_s;
  logic            fill_s;
  logic            start_s;

  function automatic logic [21:0] word_addr(input logic [IW-1:0] idx);
    logic [IW:0] w;
    w = {idx, 1'b0};
    return OFFSET + 22'(w);
  endfunction

  assign idx_s      = addr[AW-1:LB];
  assign lane_s     = addr[LB-1:0];
  assign sdram_bank = BANK;

  // Tag lookup of the current address against every valid entry
  always_comb begin
    hit_s      = 1'b0;
    hit_data_s = 32'd0;
    for (int i = 0; i < NE; i++) begin
      hit_data_s = (valid_r[i] && tag_r[i] == idx_s) ? data_r[i] : hit_data_s;
      hit_s      = hit_s | (valid_r[i] && tag_r[i] == idx_s);
    end
    lane_data_s = hit_data_s[int'(lane_s)*DW +: DW];
  end

  // Next-state logic; ack together with data_rdy in REQ fills directly
  always_comb begin
    state_s = state_r;
    fill_s  = 1'b0;
    start_s = 1'b0;
    if (loop_rst) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (cs && !hit_s) begin
            state_s = REQ;
            start_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        REQ: begin
          if (sdram_ack && data_rdy) begin
            state_s = IDLE;
            fill_s  = 1'b1;
          end else if (sdram_ack) begin
            state_s = WAIT;
          end else begin
            state_s = REQ;
          end
        end
        WAIT: begin
          if (data_rdy) begin
            state_s = IDLE;
            fill_s  = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end
        default: state_s = IDLE;
      endcase
    end
  end

  // State register and SDRAM request outputs, address latched at request start
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= 22'd0;
      req_idx_r  <= '0;
    end else begin
      state_r   <= state_s;
      sdram_req <= (state_s == REQ);
      if (start_s) begin
        sdram_addr <= word_addr(idx_s);
        req_idx_r  <= idx_s;
      end
    end
  end

  // Cache fill into the replacement entry; loop_rst invalidates everything
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NE; i++) begin
        valid_r[i] <= 1'b0;
        tag_r[i]   <= '0;
        data_r[i]  <= 32'd0;
      end
      rptr_r <= 1'b0;
    end else if (loop_rst) begin
      for (int i = 0; i < NE; i++) begin
        valid_r[i] <= 1'b0;
      end
    end else if (fill_s) begin
      for (int i = 0; i < NE; i++) begin
        if (rptr_r == 1'(i)) begin
          valid_r[i] <= 1'b1;
          tag_r[i]   <= req_idx_r;
          data_r[i]  <= data_read;
        end
      end
`ifdef JTFRAME_ROM_CLIENT_2WAY_EN
      rptr_r <= ~rptr_r;
`else
      rptr_r <= 1'b0;
`endif
    end
  end

  // Registered read data: valid only for a hit on the address presented now
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      data_ok <= 1'b0;
      dout    <= '0;
    end else begin
      data_ok <= cs && hit_s && !loop_rst;
      if (cs && hit_s) begin
        dout <= lane_data_s;
      end
    end
  end

endmodule

// File: doc/jtframe_rom_client.md
JTFRAME_ROM_CLIENT -- requirements
Module: jtframe_rom_client

Interface
REQ-001 Parameter AW, default 16: game address width in DW-sized units.
REQ-002 Parameter DW, default 8: game data width; legal values 8 or 16 only.
REQ-003 Parameter OFFSET, default 22'd0: base SDRAM address, in 16-bit words, added to every request.
REQ-004 Parameter BANK, default 2'd0: constant value driven on sdram_bank.
REQ-005 clk_sys  in  1: sole clock, rising edge.
REQ-006 rst_n  in  1: reset, asynchronous assert, active-low.
REQ-007 loop_rst  in  1: SDRAM controller init phase; while high, invalidates the cache and inhibits requests.
REQ-008 addr  in  AW: game read address.
REQ-009 cs  in  1: game read strobe, level.
REQ-010 dout  out  DW: read data to the game.
REQ-011 data_ok  out  1: dout valid for the current addr.
REQ-012 sdram_req  out  1: request to the SDRAM controller.
REQ-013 sdram_addr  out  22: SDRAM word address.
REQ-014 sdram_bank  out  2: SDRAM bank.
REQ-015 sdram_ack  in  1: one-cycle pulse; request accepted.
REQ-016 data_read  in  32: SDRAM read data, lowest game address in bits [7:0].
REQ-017 data_rdy  in  1: one-cycle pulse; data_read valid.

Function
REQ-018 The block SHALL derive word index and lane: DW=8 -> idx=addr[AW-1:2], lane=addr[1:0]; DW=16 -> idx=addr[AW-1:1], lane=addr[0].
REQ-019 sdram_addr SHALL be OFFSET + {idx,1'b0}, truncated to 22 bits; wrap-around past 22'h3FFFFF is permitted, not flagged.
REQ-020 sdram_bank SHALL equal BANK at all times.
REQ-021 Cache: each entry holds valid, tag (idx) and 32-bit data.
REQ-022 Hit: cs high and idx matches a valid entry -> dout = selected lane and data_ok high on the next rising edge; no SDRAM request.
REQ-023 FSM states: IDLE, REQ, WAIT.
REQ-024 IDLE -> REQ on cs high, miss and loop_rst low; sdram_req asserts in the same edge.
REQ-025 REQ: sdram_req and sdram_addr held stable until sdram_ack; ack -> WAIT, sdram_req deasserts the following edge.
REQ-026 WAIT: on data_rdy, data_read is written into the replacement entry, state -> IDLE; data_ok rises the next edge if addr still matches.
REQ-027 data_ok SHALL drop on the edge after addr changes to a missing idx or cs falls; never high for a stale address.
REQ-028 Address change during REQ or WAIT SHALL NOT abort; the fetch completes and fills cache, then the new addr is evaluated in IDLE.
REQ-029 ack and data_rdy in the same cycle while in REQ SHALL be treated as ack followed by fill (direct REQ -> IDLE).
REQ-030 data_rdy outside WAIT SHALL be ignored.
REQ-031 loop_rst high: all valid bits cleared, data_ok low, sdram_req low, FSM forced to IDLE.
REQ-032 Hit-to-data latency 1 cycle; miss latency = 1 + ack wait + data wait cycles.

Reset
REQ-033 rst_n low SHALL asynchronously set: FSM IDLE, sdram_req 0, data_ok 0, dout 0, all valid bits 0, replacement pointer 0.
REQ-034 Reset mid-request SHALL drop sdram_req immediately; a later stray ack/data_rdy SHALL be ignored.

Configuration
REQ-035 Macro JTFRAME_ROM_CLIENT_2WAY_EN defined: two cache entries, fill target toggles round-robin per fill.
REQ-036 Macro undefined: one cache entry, every fill overwrites it; all other behaviour identical.

Verification
REQ-037 DW=8, OFFSET=22'h100: cs=1 addr=16'h0005 -> sdram_req with sdram_addr=22'h102; ack; data_rdy data_read=32'h44332211 -> dout=8'h22, data_ok=1.
REQ-038 After REQ-037, addr=16'h0007 -> dout=8'h44 one cycle later, sdram_req stays 0.
REQ-039 2WAY_EN: fetch idx 1 then idx 9, return to idx 1 -> hit, no request; without macro -> new request.
REQ-040 sdram_ack withheld 20 cycles -> sdram_req and sdram_addr stable throughout, data_ok 0.
REQ-041 loop_rst pulse after fills -> same address misses and issues a new request.
REQ-042 rst_n low during WAIT, then data_rdy pulse -> sdram_req 0, data_ok 0, cache unchanged (empty).
